// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of the five-stage pipeline.
// Holds the PC, drives the instruction-memory address and registers the
// fetched instruction into the IF/ID pipeline register. Stall, flush and
// branch redirect are applied with fixed priorities.
// Optional build macro: FETCH_PERF_EN enables saturating stall/flush
// cycle counters; when undefined the counter ports are tied to zero.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_pc,
    input  logic                  hold_if,
    input  logic                  if_flush,
    input  logic                  pc_src,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0] pc_plus4_id,
    output logic [INST_WIDTH-1:0] inst_id,
    output logic                  valid_id,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    // Redirect targets are always word aligned; the low two bits are dropped.
    function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    // PC stage (_p0): program counter and its sequential successor.
    logic [ADDR_WIDTH-1:0] pc_p0;
    logic [ADDR_WIDTH-1:0] pc_plus4_p0;
    logic [ADDR_WIDTH-1:0] pc_next_p0;

    // IF/ID stage (_p1): registered instruction, its PC+4 and valid flag.
    logic [INST_WIDTH-1:0] inst_p1;
    logic [ADDR_WIDTH-1:0] pc_plus4_p1;
    logic                  vld_p1;
    logic [INST_WIDTH-1:0] inst_next_p1;
    logic [ADDR_WIDTH-1:0] pc_plus4_next_p1;
    logic                  vld_next_p1;

    // Sequential PC successor; wraps modulo 2^ADDR_WIDTH by width truncation.
    assign pc_plus4_p0 = pc_p0 + ADDR_WIDTH'(4);

    // Next PC: hold beats redirect, redirect beats sequential fetch.
    always_comb begin
        pc_next_p0 = pc_plus4_p0;
        if (hold_pc) begin
            pc_next_p0 = pc_p0;
        end else if (pc_src) begin
            pc_next_p0 = align_word(branch_target);
        end
    end

    // PC register; reset overrides every other control.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= pc_next_p0;
        end
    end

    // Next IF/ID contents: hold beats flush (flush is not latched), flush
    // inserts a NOP bubble, otherwise capture the fetched instruction.
    always_comb begin
        inst_next_p1     = imem_rdata;
        pc_plus4_next_p1 = pc_plus4_p0;
        vld_next_p1      = 1'b1;
        if (hold_if) begin
            inst_next_p1     = inst_p1;
            pc_plus4_next_p1 = pc_plus4_p1;
            vld_next_p1      = vld_p1;
        end else if (if_flush) begin
            inst_next_p1     = '0;
            pc_plus4_next_p1 = '0;
            vld_next_p1      = 1'b0;
        end
    end

    // IF/ID register; data fields are cleared on reset so a bubble reads as NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_p1     <= '0;
            pc_plus4_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            inst_p1     <= inst_next_p1;
            pc_plus4_p1 <= pc_plus4_next_p1;
            vld_p1      <= vld_next_p1;
        end
    end

    assign imem_addr   = pc_p0;
    assign inst_id     = inst_p1;
    assign pc_plus4_id = pc_plus4_p1;
    assign valid_id    = vld_p1;

`ifdef FETCH_PERF_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    // Stall counter counts every held-PC edge; flush counter only counts
    // flushes that actually replaced the IF/ID contents (not masked by hold).
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hold_pc) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (if_flush && !hold_if) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: two instances share the control inputs.
// Instance 0: RESET_PC=0, CNT_WIDTH=16. Instance 1: RESET_PC=0xFFFFFFFC,
// CNT_WIDTH=4 (wrap and counter saturation). Expected outputs are pushed to
// a scoreboard queue when controls are driven and popped after the edge.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        vld;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold_pc = 1'b0;
    logic        hold_if = 1'b0;
    logic        if_flush = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = '0;

    logic [31:0] addr_a, addr_b, rdata_a, rdata_b, pc4_a, pc4_b, inst_a, inst_b;
    logic        vld_a, vld_b;
    logic [15:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;

    logic [31:0] o_addr [2];
    logic [31:0] o_inst [2];
    logic [31:0] o_pc4  [2];
    logic        o_vld  [2];
    logic [15:0] o_sc   [2];
    logic [15:0] o_fc   [2];

    // Reference model state per instance.
    logic [31:0] m_pc   [2];
    logic [31:0] m_inst [2];
    logic [31:0] m_pc4  [2];
    logic        m_vld  [2];
    logic [15:0] m_sc   [2];
    logic [15:0] m_fc   [2];
    logic [31:0] rst_pc [2];
    logic [15:0] cmax   [2];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory: address-derived pattern, read combinationally.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
    endfunction

    assign rdata_a = mem(addr_a);
    assign rdata_b = mem(addr_b);

    fetch_stage #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .hold_pc(hold_pc), .hold_if(hold_if), .if_flush(if_flush),
        .pc_src(pc_src), .branch_target(branch_target), .imem_addr(addr_a),
        .imem_rdata(rdata_a), .pc_plus4_id(pc4_a), .inst_id(inst_a), .valid_id(vld_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    fetch_stage #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .hold_pc(hold_pc), .hold_if(hold_if), .if_flush(if_flush),
        .pc_src(pc_src), .branch_target(branch_target), .imem_addr(addr_b),
        .imem_rdata(rdata_b), .pc_plus4_id(pc4_b), .inst_id(inst_b), .valid_id(vld_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    assign o_addr[0] = addr_a;  assign o_addr[1] = addr_b;
    assign o_inst[0] = inst_a;  assign o_inst[1] = inst_b;
    assign o_pc4[0]  = pc4_a;   assign o_pc4[1]  = pc4_b;
    assign o_vld[0]  = vld_a;   assign o_vld[1]  = vld_b;
    assign o_sc[0]   = sc_a;    assign o_sc[1]   = {12'b0, sc_b};
    assign o_fc[0]   = fc_a;    assign o_fc[1]   = {12'b0, fc_b};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive controls, predict next state, then compare after the edge.
    task automatic step(input logic r, input logic hp, input logic hi, input logic fl,
                        input logic ps, input logic [31:0] bt);
        exp_t e;
        @(negedge clk);
        rst = r; hold_pc = hp; hold_if = hi; if_flush = fl; pc_src = ps; branch_target = bt;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] npc, ninst, npc4;
            logic        nvld;
            logic [15:0] nsc, nfc;
            npc = hp ? m_pc[k] : (ps ? {bt[31:2], 2'b00} : m_pc[k] + 32'd4);
            ninst = m_inst[k]; npc4 = m_pc4[k]; nvld = m_vld[k];
            if (!hi) begin
                if (fl) begin
                    ninst = '0; npc4 = '0; nvld = 1'b0;
                end else begin
                    ninst = mem(m_pc[k]); npc4 = m_pc[k] + 32'd4; nvld = 1'b1;
                end
            end
            nsc = m_sc[k]; nfc = m_fc[k];
`ifdef FETCH_PERF_EN
            if (hp && nsc != cmax[k]) nsc = nsc + 16'd1;
            if (fl && !hi && nfc != cmax[k]) nfc = nfc + 16'd1;
`endif
            if (r) begin
                npc = rst_pc[k]; ninst = '0; npc4 = '0; nvld = 1'b0; nsc = '0; nfc = '0;
            end
            m_pc[k] = npc; m_inst[k] = ninst; m_pc4[k] = npc4; m_vld[k] = nvld;
            m_sc[k] = nsc; m_fc[k] = nfc;
            e.addr = npc; e.inst = ninst; e.pc4 = npc4; e.vld = nvld; e.sc = nsc; e.fc = nfc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (sb.size() == 0) begin
                check_val($sformatf("sb_empty[%0d]", k), 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val($sformatf("addr[%0d]", k), 64'(o_addr[k]), 64'(e.addr));
                check_val($sformatf("inst[%0d]", k), 64'(o_inst[k]), 64'(e.inst));
                check_val($sformatf("pc4[%0d]", k),  64'(o_pc4[k]),  64'(e.pc4));
                check_val($sformatf("vld[%0d]", k),  64'(o_vld[k]),  64'(e.vld));
                check_val($sformatf("scnt[%0d]", k), 64'(o_sc[k]),   64'(e.sc));
                check_val($sformatf("fcnt[%0d]", k), 64'(o_fc[k]),   64'(e.fc));
            end
        end
    endtask

    initial begin
        logic [15:0] fc_before;
        rst_pc[0] = 32'h0;     rst_pc[1] = 32'hFFFF_FFFC;
        cmax[0]   = 16'hFFFF;  cmax[1]   = 16'h000F;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = '0; m_inst[k] = '0; m_pc4[k] = '0; m_vld[k] = 1'b0; m_sc[k] = '0; m_fc[k] = '0;
        end

        // Reset.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_val("rst_addr_a", 64'(addr_a), 64'h0);
        check_val("rst_addr_b", 64'(addr_b), 64'hFFFF_FFFC);
        check_val("rst_vld_a", 64'(vld_a), 64'd0);

        // Free run: 0 -> 4 -> 8 -> 12 -> 16; instance 1 wraps to 0.
        step(0, 0, 0, 0, 0, 0);
        check_val("wrap_addr_b", 64'(addr_b), 64'h0);
        check_val("run_inst_a", 64'(inst_a), 64'(mem(32'h0)));
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("run_addr_a", 64'(addr_a), 64'h10);

        // Load-use stall of two cycles at PC 0x10.
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        check_val("stall_addr", 64'(addr_a), 64'h10);
        check_val("stall_inst", 64'(inst_a), 64'(mem(32'hC)));
        step(0, 0, 0, 0, 0, 0);
        check_val("resume_addr", 64'(addr_a), 64'h14);

        // Taken branch with squash of the wrong-path fetch.
        step(0, 0, 0, 1, 1, 32'h103);
        check_val("br_addr", 64'(addr_a), 64'h100);
        check_val("br_bubble", 64'({inst_a, pc4_a, 31'b0, vld_a}), 64'h0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // All four controls together, then redirect/flush alone.
        fc_before = fc_a;
        step(0, 1, 1, 1, 1, 32'h200);
        step(0, 0, 0, 1, 1, 32'h200);
        check_val("simul_addr", 64'(addr_a), 64'h200);
`ifdef FETCH_PERF_EN
        check_val("simul_fcnt", 64'(fc_a), 64'(fc_before + 16'd1));
`else
        check_val("simul_fcnt", 64'(fc_a), 64'(fc_before));
`endif
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Hold PC without holding IF/ID refetches the same address.
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // Hold IF/ID masks a concurrent flush.
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Long stall: the narrow counter saturates.
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 0);
`ifdef FETCH_PERF_EN
        check_val("sat_scnt_b", 64'(sc_b), 64'hF);
`else
        check_val("sat_scnt_b", 64'(sc_b), 64'h0);
`endif

        // Reset during a stall with a flush pending.
        step(1, 1, 1, 1, 1, 32'h40);
        check_val("midrst_addr_b", 64'(addr_b), 64'hFFFF_FFFC);
        check_val("midrst_rest_b", 64'({inst_b, pc4_b}), 64'h0);

        // Randomised control traffic.
        for (int i = 0; i < 60; i++) begin
            logic hp, r;
            hp = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 15) == 0);
            step(r, hp, hp | ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
